// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder: controller state encoding and
// the legal WIDTH range.
package serial_add_pkg;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_fa.sv
// Combinational full-adder slice built from two half-adder cells, the single
// arithmetic element time-shared by the serial adder.
module serial_ha (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);

  assign s = x ^ y;
  assign c = x & y;

endmodule

module serial_fa (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;
  logic g0;
  logic g1;

  serial_ha u_ha0 (.x(x), .y(y),  .s(p), .c(g0));
  serial_ha u_ha1 (.x(p), .y(ci), .s(s), .c(g1));

  // At most one of the half-adder carries can be set, so OR gives the majority.
  assign co = g0 | g1;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: captures operands, runs one full-adder slice
// LSB first for WIDTH cycles, then presents a registered {cout,sum}.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  generate
    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
      $error("serial_add_ctrl: WIDTH %0d outside legal range", WIDTH);
    end
  endgenerate

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-2:0] ss;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s;
  logic             fa_co;
  logic             last;
  logic [WIDTH-1:0] ss_full;

  serial_fa u_fa (
    .x  (sa[0]),
    .y  (sb[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  assign last    = (cnt == CW'(WIDTH - 1));
  // ss keeps only the upper WIDTH-1 result bits; the LSB falls out on the final shift.
  assign ss_full = {fa_s, ss};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = S_IDLE;
    case (state)
      S_IDLE:  state_next = start ? S_RUN : S_IDLE;
      S_RUN:   state_next = last ? S_DONE : S_RUN;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa    <= '0;
      sb    <= '0;
      ss    <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            sa    <= a;
            sb    <= b;
            carry <= cin;
            cnt   <= '0;
          end
        end
        S_RUN: begin
          sa    <= {1'b0, sa[WIDTH-1:1]};
          sb    <= {1'b0, sb[WIDTH-1:1]};
          ss    <= ss_full[WIDTH-1:1];
          carry <= fa_co;
          cnt   <= cnt + CW'(1);
          if (last) begin
            sum  <= ss_full;
            cout <= fa_co;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == S_RUN) || (state == S_DONE);
  assign done = (state == S_DONE);

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial N-bit adder: one full-adder slice, built from two half-adder cells plus a carry flip-flop, is time-shared across all WIDTH bit positions, LSB first.
- The FSM captures the operands, sequences the slice for WIDTH cycles, and presents a registered result with a start/busy/done handshake.
- Trades area for latency; intended for lab datapaths that need many adders of one narrow cell.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- CW, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  sole clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- cin  input  1  carry-in; captured on the accepting edge.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse in DONE.
- sum  output  WIDTH  registered result; held until next completion.
- cout  output  1  registered carry-out; held with sum.

Behaviour:
- Reset (rst_n=0, asynchronous, any state): state=IDLE; busy=0, done=0, sum=0, cout=0; shift registers, carry FF and counter cleared. Deassertion is synchronous to clk.
- States: IDLE, RUN, DONE. Encoding lives in the shared package.
- IDLE: when start=1 at an edge, load sa<=a, sb<=b, carry<=cin, cnt<=0, and go to RUN. When start=0, stay.
- RUN: slice inputs are sa[0], sb[0] and carry. Slice outputs: s = sa[0]^sb[0]^carry; co = majority(sa[0], sb[0], carry).
- RUN, each edge: sa>>=1, sb>>=1 (zero fill); ss <= {s, ss[WIDTH-1:1]}; carry <= co; cnt <= cnt+1.
- RUN, edge where cnt==WIDTH-1: sum <= {s, ss[WIDTH-1:1]} and cout <= co, then go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- start is ignored in RUN and DONE. No queuing; start must be re-asserted in IDLE.
- Latency: accepting edge = E0. done is high during the cycle after edge E0+WIDTH. Minimum issue interval is WIDTH+2 cycles.
- sum/cout change only on the RUN→DONE edge. They remain stable through IDLE and the whole of the next RUN.
- Operand inputs may change freely after E0; only the captured copies are used.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1), exactly.
- Reset asserted mid-RUN aborts the operation. No done pulse occurs; sum/cout read 0.
- busy is registered (decoded from the state register), with no combinational path from start.

Decomposition:
- Package serial_add_pkg:
  - state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2; 2'd3 recovers to IDLE);
  - WIDTH bounds check constants.
- Sub-module serial_fa: purely combinational full-adder slice.
  - Two half-adder cell instances plus an OR on the two carries.
  - Ports x, y, ci, s, co.
- The controller instantiates exactly one serial_fa.

Test Plan:
1. WIDTH=8, a=8'h3C, b=8'h5A, cin=0, start pulse at E0 → busy from E0; done in cycle after E0+8; sum=8'h96, cout=0.
2. a=8'hFF, b=8'h01, cin=0 → sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 → sum=8'hFF, cout=1.
3. start held high continuously, with a/b changing every cycle during RUN → only E0 values used. Exactly one done every 10 cycles. sum stable between done pulses.
4. rst_n driven low at E0+4 of an operation → all outputs 0 asynchronously; no done. After release, start with a=8'h01, b=8'h02 → sum=8'h03.
5. Back-to-back: start asserted during the DONE cycle → ignored. start asserted the next cycle (IDLE) → accepted; previous sum held until new done.
6. Randomized 1000 operations at WIDTH=8 and WIDTH=2 → {cout,sum} equals a+b+cin against the reference model; done pulse width always 1.
